pipeline_sequencer: RTL and testbench

Hazard and flow sequencer for the 16-bit five-stage CPU. It watches the ID and EX stage occupants and drives the PC stop/select lines and the hold/flush controls of the IF/ID, ID/EX and EX/MEM buffers. It covers load-use stalls, branch/jump squashes, multi-cycle multiply/divide occupancy of EX, halt, and an optional overflow trap. All stall and flush outputs are same-cycle functions of state and inputs; the state updates on the clock edge.

---
 rtl/pipeline_sequencer.sv | 150 +++++++++++++++
 tb/tb_pipeline_sequencer.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Hazard/flow sequencer for the five-stage CPU: stalls, squashes, mul/div occupancy, halt.
// Define PIPELINE_SEQ_OVERFLOW_TRAP_EN to enable the ALU overflow trap (TRAP state, exception output).
module pipeline_sequencer #(
    parameter int unsigned MD_CYCLES = 4,
    parameter int unsigned CNT_W     = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] id_rs1,
    input  logic [3:0] id_rs2,
    input  logic       id_uses_rs2,
    input  logic       id_jump,
    input  logic       id_halt,
    input  logic [3:0] ex_rd,
    input  logic       ex_is_load,
    input  logic       ex_is_muldiv,
    input  logic       ex_branch_taken,
    input  logic       ex_overflow,
    input  logic       resume,
    output logic       pc_stop,
    output logic       pc_sel,
    output logic       if_id_hold,
    output logic       if_id_flush,
    output logic       id_ex_hold,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       md_busy,
    output logic       halted,
    output logic       exception
);

    typedef enum logic [1:0] {RUN, MD_WAIT, HALT, TRAP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             load_use;
    logic             overflow;

`ifdef PIPELINE_SEQ_OVERFLOW_TRAP_EN
    assign overflow = ex_overflow;
`else
    logic unused_overflow;
    assign unused_overflow = ex_overflow;
    assign overflow        = 1'b0;
`endif

    // r0 is hardwired zero, so a load targeting it never creates a dependency
    assign load_use = ex_is_load && (ex_rd != 4'd0) &&
                      ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

    always_comb begin
        pc_stop      = 1'b0;
        pc_sel       = 1'b0;
        if_id_hold   = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        md_busy      = 1'b0;
        halted       = 1'b0;
        exception    = 1'b0;
        state_next   = state;
        cnt_next     = cnt;

        // Outputs are combinational on inputs, so they must be forced low during reset
        if (reset) begin
            unique case (state)
                RUN: begin
                    if (overflow) begin
                        pc_stop      = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        state_next   = TRAP;
                    end else if (ex_branch_taken) begin
                        pc_sel      = 1'b1;
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ex_is_muldiv) begin
                        pc_stop      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_hold   = 1'b1;
                        ex_mem_flush = 1'b1;
                        cnt_next     = CNT_W'(MD_CYCLES - 2);
                        state_next   = MD_WAIT;
                    end else if (load_use) begin
                        pc_stop     = 1'b1;
                        if_id_hold  = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (id_jump) begin
                        pc_sel      = 1'b1;
                        if_id_flush = 1'b1;
                    end else if (id_halt) begin
                        pc_stop     = 1'b1;
                        if_id_flush = 1'b1;
                        state_next  = HALT;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    if (cnt != '0) begin
                        pc_stop      = 1'b1;
                        if_id_hold   = 1'b1;
                        id_ex_hold   = 1'b1;
                        ex_mem_flush = 1'b1;
                        cnt_next     = cnt - CNT_W'(1);
                    end else if (overflow) begin
                        pc_stop      = 1'b1;
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        state_next   = TRAP;
                    end else begin
                        // Release cycle: hazards seen now are re-evaluated next cycle in RUN
                        state_next = RUN;
                    end
                end
                HALT: begin
                    pc_stop     = 1'b1;
                    if_id_flush = 1'b1;
                    halted      = 1'b1;
                    if (resume) state_next = RUN;
                end
                TRAP: begin
`ifdef PIPELINE_SEQ_OVERFLOW_TRAP_EN
                    pc_stop     = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    exception   = 1'b1;
                    if (resume) state_next = RUN;
`else
                    state_next = RUN;
`endif
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Self-checking bench for pipeline_sequencer: directed scenarios plus randomized run against a flag/counter model.
// Overflow expectations follow PIPELINE_SEQ_OVERFLOW_TRAP_EN as defined for the build.
module tb_pipeline_sequencer;

    localparam int unsigned MD = 4;
`ifdef PIPELINE_SEQ_OVERFLOW_TRAP_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    localparam logic [9:0] O_STOP = 10'b10_0000_0000;
    localparam logic [9:0] O_SEL  = 10'b01_0000_0000;
    localparam logic [9:0] O_IFH  = 10'b00_1000_0000;
    localparam logic [9:0] O_IFF  = 10'b00_0100_0000;
    localparam logic [9:0] O_IDH  = 10'b00_0010_0000;
    localparam logic [9:0] O_IDF  = 10'b00_0001_0000;
    localparam logic [9:0] O_EMF  = 10'b00_0000_1000;
    localparam logic [9:0] O_BUSY = 10'b00_0000_0100;
    localparam logic [9:0] O_HALT = 10'b00_0000_0010;
    localparam logic [9:0] O_EXC  = 10'b00_0000_0001;
    localparam logic [9:0] MD_HOLD = O_STOP | O_IFH | O_IDH | O_EMF;
    localparam logic [9:0] LU_STALL = O_STOP | O_IFH | O_IDF;

    logic       clock, reset;
    logic [3:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, id_jump, id_halt, ex_is_load, ex_is_muldiv;
    logic       ex_branch_taken, ex_overflow, resume;
    logic       pc_stop, pc_sel, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush;
    logic       ex_mem_flush, md_busy, halted, exception;
    logic [9:0] outs;
    logic [9:0] exp;

    int checks   = 0;
    int failures = 0;

    // Reference model: plain flags and a count of EX-occupancy cycles still to come
    bit m_halted, m_trapped;
    int m_md_left;

    assign outs = {pc_stop, pc_sel, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush,
                   ex_mem_flush, md_busy, halted, exception};

    pipeline_sequencer #(.MD_CYCLES(MD), .CNT_W(4)) dut (
        .clock(clock), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .id_jump(id_jump), .id_halt(id_halt),
        .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_is_muldiv(ex_is_muldiv),
        .ex_branch_taken(ex_branch_taken), .ex_overflow(ex_overflow), .resume(resume),
        .pc_stop(pc_stop), .pc_sel(pc_sel), .if_id_hold(if_id_hold), .if_id_flush(if_id_flush),
        .id_ex_hold(id_ex_hold), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
        .md_busy(md_busy), .halted(halted), .exception(exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_idle();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0; id_uses_rs2 = 0; id_jump = 0; id_halt = 0;
        ex_is_load = 0; ex_is_muldiv = 0; ex_branch_taken = 0; ex_overflow = 0; resume = 0;
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
    endtask

    function automatic bit model_load_use();
        return ex_is_load && ex_rd != 0 && (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
    endfunction

    function automatic logic [9:0] model_outs();
        bit ovf = OVF_EN && ex_overflow;
        if (!reset) return '0;
        if (m_halted) return O_STOP | O_IFF | O_HALT;
        if (m_trapped) return O_STOP | O_IFF | O_IDF | O_EXC;
        if (m_md_left > 1) return MD_HOLD | O_BUSY;
        if (m_md_left == 1) return ovf ? (O_STOP | O_IFF | O_IDF | O_EMF | O_BUSY) : O_BUSY;
        if (ovf) return O_STOP | O_IFF | O_IDF | O_EMF;
        if (ex_branch_taken) return O_SEL | O_IFF | O_IDF;
        if (ex_is_muldiv) return MD_HOLD;
        if (model_load_use()) return LU_STALL;
        if (id_jump) return O_SEL | O_IFF;
        if (id_halt) return O_STOP | O_IFF;
        return '0;
    endfunction

    task automatic model_advance();
        bit ovf = OVF_EN && ex_overflow;
        if (!reset) begin
            m_halted = 0; m_trapped = 0; m_md_left = 0;
        end else if (m_halted) begin
            if (resume) m_halted = 0;
        end else if (m_trapped) begin
            if (resume) m_trapped = 0;
        end else if (m_md_left > 0) begin
            if (m_md_left == 1 && ovf) m_trapped = 1;
            m_md_left = m_md_left - 1;
        end else if (ovf) begin
            m_trapped = 1;
        end else if (!ex_branch_taken) begin
            if (ex_is_muldiv) m_md_left = MD - 1;
            else if (!model_load_use() && !id_jump && id_halt) m_halted = 1;
        end
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        ex_is_muldiv = 1; id_halt = 1; ex_branch_taken = 1; ex_overflow = 1; id_jump = 1;
        @(negedge clock);
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_held: got %b expected %b", outs, 10'b0);
        end
        next_cycle();
        set_idle();
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL reset_release_idle: got %b expected %b", outs, 10'b0);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_is_load = 1; ex_rd = 4'd3; id_rs1 = 4'd3;
        @(negedge clock);
        checks++;
        if (outs !== LU_STALL) begin
            failures++;
            $display("FAIL load_use_rs1: got %b expected %b", outs, LU_STALL);
        end
        next_cycle();
        ex_is_load = 0;
        @(negedge clock);
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL load_use_single_stall: got %b expected %b", outs, 10'b0);
        end
        next_cycle();
        ex_is_load = 1; ex_rd = 4'd0; id_rs1 = 4'd0;
        @(negedge clock);
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL load_use_r0: got %b expected %b", outs, 10'b0);
        end
        next_cycle();
        ex_rd = 4'd5; id_rs1 = 4'd1; id_rs2 = 4'd5; id_uses_rs2 = 1;
        @(negedge clock);
        checks++;
        if (outs !== LU_STALL) begin
            failures++;
            $display("FAIL load_use_rs2: got %b expected %b", outs, LU_STALL);
        end
        next_cycle();
        id_uses_rs2 = 0;
        @(negedge clock);
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL load_use_rs2_unused: got %b expected %b", outs, 10'b0);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_muldiv();
        do_reset();
        ex_is_muldiv = 1;
        for (int c = 1; c <= int'(MD); c++) begin
            if (c == int'(MD)) begin
                ex_is_muldiv = 0; ex_is_load = 1; ex_rd = 4'd2; id_rs1 = 4'd2;
            end
            exp = (c == 1) ? MD_HOLD : (c < int'(MD)) ? (MD_HOLD | O_BUSY) : O_BUSY;
            @(negedge clock);
            checks++;
            if (outs !== exp) begin
                failures++;
                $display("FAIL muldiv_cycle%0d: got %b expected %b", c, outs, exp);
            end
            next_cycle();
        end
        @(negedge clock);
        checks++;
        if (outs !== LU_STALL) begin
            failures++;
            $display("FAIL muldiv_release_then_load_use: got %b expected %b", outs, LU_STALL);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_priority();
        do_reset();
        ex_branch_taken = 1; id_halt = 1; ex_is_muldiv = 1;
        @(negedge clock);
        checks++;
        if (outs !== (O_SEL | O_IFF | O_IDF)) begin
            failures++;
            $display("FAIL prio_branch: got %b expected %b", outs, O_SEL | O_IFF | O_IDF);
        end
        next_cycle();
        set_idle();
        @(negedge clock);
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL prio_branch_no_halt: got %b expected %b", outs, 10'b0);
        end
        next_cycle();
        ex_is_load = 1; ex_rd = 4'd7; id_rs1 = 4'd7; id_jump = 1; id_halt = 1;
        @(negedge clock);
        checks++;
        if (outs !== LU_STALL) begin
            failures++;
            $display("FAIL prio_load_use_over_jump: got %b expected %b", outs, LU_STALL);
        end
        next_cycle();
        ex_is_load = 0;
        @(negedge clock);
        checks++;
        if (outs !== (O_SEL | O_IFF)) begin
            failures++;
            $display("FAIL prio_jump_over_halt: got %b expected %b", outs, O_SEL | O_IFF);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_halt();
        do_reset();
        id_halt = 1;
        @(negedge clock);
        checks++;
        if (outs !== (O_STOP | O_IFF)) begin
            failures++;
            $display("FAIL halt_entry: got %b expected %b", outs, O_STOP | O_IFF);
        end
        next_cycle();
        id_halt = 0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) resume = 1;
            @(negedge clock);
            checks++;
            if (outs !== (O_STOP | O_IFF | O_HALT)) begin
                failures++;
                $display("FAIL halt_hold%0d: got %b expected %b", c, outs, O_STOP | O_IFF | O_HALT);
            end
            next_cycle();
        end
        resume = 0;
        @(negedge clock);
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL halt_resume: got %b expected %b", outs, 10'b0);
        end
        next_cycle();
    endtask

    task automatic test_overflow();
        do_reset();
        ex_overflow = 1; ex_branch_taken = 1;
`ifdef PIPELINE_SEQ_OVERFLOW_TRAP_EN
        exp = O_STOP | O_IFF | O_IDF | O_EMF;
`else
        exp = O_SEL | O_IFF | O_IDF;
`endif
        @(negedge clock);
        checks++;
        if (outs !== exp) begin
            failures++;
            $display("FAIL overflow_entry: got %b expected %b", outs, exp);
        end
        next_cycle();
        set_idle();
        for (int c = 0; c < 3; c++) begin
            if (c == 2) resume = 1;
`ifdef PIPELINE_SEQ_OVERFLOW_TRAP_EN
            exp = O_STOP | O_IFF | O_IDF | O_EXC;
`else
            exp = '0;
`endif
            @(negedge clock);
            checks++;
            if (outs !== exp) begin
                failures++;
                $display("FAIL overflow_trap%0d: got %b expected %b", c, outs, exp);
            end
            next_cycle();
        end
        resume = 0;
        @(negedge clock);
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL overflow_resume: got %b expected %b", outs, 10'b0);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_md();
        do_reset();
        ex_is_muldiv = 1;
        next_cycle();
        @(negedge clock);
        checks++;
        if (outs !== (MD_HOLD | O_BUSY)) begin
            failures++;
            $display("FAIL mid_md_before_reset: got %b expected %b", outs, MD_HOLD | O_BUSY);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL mid_md_async_reset: got %b expected %b", outs, 10'b0);
        end
        next_cycle();
        ex_is_muldiv = 0;
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (outs !== '0) begin
            failures++;
            $display("FAIL mid_md_after_release: got %b expected %b", outs, 10'b0);
        end
        next_cycle();
        ex_is_load = 1; ex_rd = 4'd9; id_rs1 = 4'd9;
        @(negedge clock);
        checks++;
        if (outs !== LU_STALL) begin
            failures++;
            $display("FAIL mid_md_back_in_run: got %b expected %b", outs, LU_STALL);
        end
        next_cycle();
        set_idle();
    endtask

    task automatic test_random();
        do_reset();
        m_halted = 0; m_trapped = 0; m_md_left = 0;
        for (int i = 0; i < 3000; i++) begin
            reset           = ($urandom_range(0, 59) != 0);
            id_rs1          = 4'($urandom_range(0, 3));
            id_rs2          = 4'($urandom_range(0, 3));
            ex_rd           = 4'($urandom_range(0, 3));
            id_uses_rs2     = ($urandom_range(0, 1) == 0);
            ex_is_load      = ($urandom_range(0, 2) == 0);
            ex_is_muldiv    = ($urandom_range(0, 7) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            id_jump         = ($urandom_range(0, 7) == 0);
            id_halt         = ($urandom_range(0, 11) == 0);
            ex_overflow     = ($urandom_range(0, 9) == 0);
            resume          = ($urandom_range(0, 3) == 0);
            @(negedge clock);
            exp = model_outs();
            checks++;
            if (outs !== exp) begin
                failures++;
                $display("FAIL random_cycle%0d: got %b expected %b", i, outs, exp);
            end
            model_advance();
            next_cycle();
        end
        set_idle();
        reset = 1'b1;
    endtask

    initial begin
        set_idle();
        reset = 1'b0;
        #1;
        test_reset();
        test_load_use();
        test_muldiv();
        test_priority();
        test_halt();
        test_overflow();
        test_reset_mid_md();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
